// File: rtl/decode_stage.sv
// Registered decode stage with load-use interlock and HLT drain/halt FSM; control word appears one edge after accept.
// Backpressure: instr_rdy drops on load-use hazard, during drain and once halted; the stage itself is never stalled downstream.
module decode_stage #(
   parameter int IW        = 16,
   parameter int RW        = 4,
   parameter int DRAIN_CYC = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_vld,
   input  logic [IW-1:0] instr,
   output logic          instr_rdy,
   input  logic          z_flag,
   input  logic          flush,
   output logic          ctl_vld,
   output logic          rdEnReg1,
   output logic          rdEnReg2,
   output logic          wrRegEn,
   output logic          memRd,
   output logic          memWr,
   output logic          mem2reg,
   output logic          sawBr,
   output logic          sawJ,
   output logic          aluSrc,
   output logic [RW-1:0] rdReg1,
   output logic [RW-1:0] rdReg2,
   output logic [RW-1:0] wrReg,
   output logic [3:0]    aluOp,
   output logic [3:0]    shAmt,
   output logic          halted
);

   // Opcode and ALU encodings shared with the single-cycle core's defines.v.
   localparam logic [3:0] OP_ADD = 4'h0, OP_ADDZ = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                          OP_NOR = 4'h4, OP_SLL  = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
                          OP_LW  = 4'h8, OP_SW   = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB,
                          OP_B   = 4'hC, OP_JAL  = 4'hD, OP_JR  = 4'hE, OP_HLT = 4'hF;
   localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_NOR = 4'h3,
                          ALU_SLL = 4'h4, ALU_SRL = 4'h5, ALU_SRA = 4'h6, ALU_LHB = 4'h7,
                          ALU_LLB = 4'h8, ALU_NOP = 4'hF;

   typedef struct packed {
      logic          rd1;
      logic          rd2;
      logic          wr;
      logic          mrd;
      logic          mwr;
      logic          br;
      logic          j;
      logic [RW-1:0] r1;
      logic [RW-1:0] r2;
      logic [RW-1:0] w;
      logic [3:0]    alu;
      logic [3:0]    sh;
   } ctl_t;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   ctl_t       ctl_q, ctl_d, dec;
   logic       vld_q, vld_d;
   logic [3:0] opc;
   logic       load_use, stall, take;

   assign opc = instr[IW-1:IW-4];

   always_comb begin
      dec     = '0;
      dec.r1  = (opc == OP_LHB || opc == OP_SW) ? RW'(instr[11:8]) : RW'(instr[7:4]);
      dec.r2  = RW'(instr[3:0]);
      dec.sh  = instr[3:0];
      dec.w   = (opc == OP_JAL) ? '1 : RW'(instr[11:8]);
      case (opc)
         OP_ADD:  begin dec.rd1 = 1'b1; dec.rd2 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_ADD; end
         OP_ADDZ: begin dec.rd1 = 1'b1; dec.rd2 = 1'b1; dec.wr = z_flag;
                        dec.alu = z_flag ? ALU_ADD : ALU_NOP; end
         OP_SUB:  begin dec.rd1 = 1'b1; dec.rd2 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_SUB; end
         OP_AND:  begin dec.rd1 = 1'b1; dec.rd2 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_AND; end
         OP_NOR:  begin dec.rd1 = 1'b1; dec.rd2 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_NOR; end
         OP_SLL:  begin dec.rd1 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_SLL; end
         OP_SRL:  begin dec.rd1 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_SRL; end
         OP_SRA:  begin dec.rd1 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_SRA; end
         OP_LW:   begin dec.rd1 = 1'b1; dec.wr = 1'b1; dec.mrd = 1'b1; dec.alu = ALU_ADD; end
         OP_SW:   begin dec.rd1 = 1'b1; dec.mwr = 1'b1; dec.alu = ALU_ADD; end
         OP_LHB:  begin dec.rd1 = 1'b1; dec.wr = 1'b1; dec.alu = ALU_LHB; end
         OP_LLB:  begin dec.wr = 1'b1; dec.alu = ALU_LLB; end
         OP_B:    begin dec.br = 1'b1; end
         OP_JAL:  begin dec.j = 1'b1; dec.wr = 1'b1; end
         OP_JR:   begin dec.j = 1'b1; dec.rd1 = 1'b1; end
         default: begin end
      endcase
   end

   // The bubble loaded during a stall clears the LW from the output register, so a stall lasts one cycle.
   assign load_use  = vld_q & ctl_q.mrd &
                      ((dec.rd1 & (dec.r1 == ctl_q.w)) | (dec.rd2 & (dec.r2 == ctl_q.w)));
   assign stall     = load_use & ~flush;
   assign instr_rdy = (state_q == RUN) & ~stall;
   assign take      = instr_vld & instr_rdy & ~flush;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (take && opc == OP_HLT) begin
               state_d = DRAIN;
               cnt_d   = 4'd0;
            end
         end
         DRAIN: begin
            if (flush) begin
               state_d = RUN;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'(DRAIN_CYC - 1)) begin
               state_d = HALTED;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   assign ctl_d = take ? dec : '0;
   assign vld_d = take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
         ctl_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctl_q   <= ctl_d;
         vld_q   <= vld_d;
      end
   end

   assign ctl_vld  = vld_q;
   assign rdEnReg1 = ctl_q.rd1;
   assign rdEnReg2 = ctl_q.rd2;
   assign wrRegEn  = ctl_q.wr;
   assign memRd    = ctl_q.mrd;
   assign memWr    = ctl_q.mwr;
   assign mem2reg  = ctl_q.mrd;
   assign sawBr    = ctl_q.br;
   assign sawJ     = ctl_q.j;
   assign aluSrc   = ctl_q.rd2;
   assign rdReg1   = ctl_q.r1;
   assign rdReg2   = ctl_q.r2;
   assign wrReg    = ctl_q.w;
   assign aluOp    = ctl_q.alu;
   assign shAmt    = ctl_q.sh;
   assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboarded bench for decode_stage: expected control words queued at accept, compared one edge later.
module tb_decode_stage;

   localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_NOR = 4'h3,
                          A_SLL = 4'h4, A_SRL = 4'h5, A_SRA = 4'h6, A_LHB = 4'h7,
                          A_LLB = 4'h8, A_NOP = 4'hF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_vld = 1'b0;
   logic [15:0] instr = 16'h0;
   logic        z_flag = 1'b0;
   logic        flush = 1'b0;
   logic        instr_rdy, ctl_vld, halted;
   logic        rdEnReg1, rdEnReg2, wrRegEn, memRd, memWr, mem2reg, sawBr, sawJ, aluSrc;
   logic [3:0]  rdReg1, rdReg2, wrReg, aluOp, shAmt;

   int n_chk = 0;
   int n_err = 0;
   logic [29:0] sb[$];

   decode_stage #(.IW(16), .RW(4), .DRAIN_CYC(3)) dut (
      .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld), .instr(instr), .instr_rdy(instr_rdy),
      .z_flag(z_flag), .flush(flush), .ctl_vld(ctl_vld),
      .rdEnReg1(rdEnReg1), .rdEnReg2(rdEnReg2), .wrRegEn(wrRegEn), .memRd(memRd),
      .memWr(memWr), .mem2reg(mem2reg), .sawBr(sawBr), .sawJ(sawJ), .aluSrc(aluSrc),
      .rdReg1(rdReg1), .rdReg2(rdReg2), .wrReg(wrReg), .aluOp(aluOp), .shAmt(shAmt),
      .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [29:0] obs();
      return {ctl_vld, rdEnReg1, rdEnReg2, wrRegEn, memRd, memWr, mem2reg, sawBr, sawJ, aluSrc,
              rdReg1, rdReg2, wrReg, aluOp, shAmt};
   endfunction

   // Reference decode: {vld, rd1, rd2, wr, mrd, mwr, m2r, br, j, aluSrc, r1, r2, w, alu, sh}
   function automatic logic [29:0] model(input logic [15:0] i, input logic z);
      logic [3:0] op, a, b, c, r1, w, alu;
      logic r1e, r2e, we, mr, mw, br, j;
      op = i[15:12]; a = i[11:8]; b = i[7:4]; c = i[3:0];
      {r1e, r2e, we, mr, mw, br, j} = 7'b0;
      alu = 4'h0;
      r1  = (op == 4'hA || op == 4'h9) ? a : b;
      w   = (op == 4'hD) ? 4'hF : a;
      case (op)
         4'h0: begin {r1e, r2e, we} = 3'b111; alu = A_ADD; end
         4'h1: begin r1e = 1; r2e = 1; we = z; alu = z ? A_ADD : A_NOP; end
         4'h2: begin {r1e, r2e, we} = 3'b111; alu = A_SUB; end
         4'h3: begin {r1e, r2e, we} = 3'b111; alu = A_AND; end
         4'h4: begin {r1e, r2e, we} = 3'b111; alu = A_NOR; end
         4'h5: begin r1e = 1; we = 1; alu = A_SLL; end
         4'h6: begin r1e = 1; we = 1; alu = A_SRL; end
         4'h7: begin r1e = 1; we = 1; alu = A_SRA; end
         4'h8: begin r1e = 1; we = 1; mr = 1; alu = A_ADD; end
         4'h9: begin r1e = 1; mw = 1; alu = A_ADD; end
         4'hA: begin r1e = 1; we = 1; alu = A_LHB; end
         4'hB: begin we = 1; alu = A_LLB; end
         4'hC: br = 1;
         4'hD: begin j = 1; we = 1; end
         4'hE: begin j = 1; r1e = 1; end
         default: ;
      endcase
      return {1'b1, r1e, r2e, we, mr, mw, mr, br, j, r2e, r1, c, w, alu, c};
   endfunction

   // Called at posedge+1: drives one cycle, checks ready, then checks the registered outputs after the edge.
   task automatic drive(input logic v, input logic [15:0] i, input logic z, input logic f,
                        input logic exp_rdy, input logic exp_halt, input string tag);
      instr_vld = v; instr = i; z_flag = z; flush = f;
      #1;
      check_eq({tag, "_rdy"}, {31'b0, instr_rdy}, {31'b0, exp_rdy});
      if (v && exp_rdy && !f) sb.push_back(model(i, z));
      @(posedge clk); #1;
      if (sb.size() > 0) check_eq({tag, "_ctl"}, {2'b0, obs()}, {2'b0, sb.pop_front()});
      else               check_eq({tag, "_bub"}, {2'b0, obs()}, 32'h0);
      check_eq({tag, "_halt"}, {31'b0, halted}, {31'b0, exp_halt});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out", {2'b0, obs()}, 32'h0);
      check_eq("rst_halt", {31'b0, halted}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic decode across formats
      drive(1, 16'h0312, 0, 0, 1, 0, "add");
      drive(1, 16'h2678, 0, 0, 1, 0, "sub");
      drive(1, 16'h1123, 0, 0, 1, 0, "addz0");
      drive(1, 16'h1123, 1, 0, 1, 0, "addz1");
      drive(1, 16'h5A27, 0, 0, 1, 0, "sll");
      drive(1, 16'hC000, 0, 0, 1, 0, "br");
      drive(1, 16'hD000, 0, 0, 1, 0, "jal");
      drive(1, 16'hA5CC, 0, 0, 1, 0, "lhb");
      drive(0, 16'h0312, 0, 0, 1, 0, "idle");

      // Load-use: one-cycle stall then issue
      drive(1, 16'h8415, 0, 0, 1, 0, "lw4");
      drive(1, 16'h0541, 0, 0, 0, 0, "lu_stall");
      drive(1, 16'h0541, 0, 0, 1, 0, "lu_issue");

      // Store data register hazard cleared by flush; flushed instruction discarded
      drive(1, 16'h8230, 0, 0, 1, 0, "lw2");
      drive(1, 16'h9215, 0, 1, 1, 0, "sw_flush");
      drive(1, 16'h9215, 0, 0, 1, 0, "sw");

      // rdReg2 match without read enable must not stall; JR match must
      drive(1, 16'h8510, 0, 0, 1, 0, "lw5a");
      drive(1, 16'h5315, 0, 0, 1, 0, "sll_nostall");
      drive(1, 16'h8510, 0, 0, 1, 0, "lw5b");
      drive(1, 16'hE050, 0, 0, 0, 0, "jr_stall");
      drive(1, 16'hE050, 0, 0, 1, 0, "jr");
      drive(1, 16'h3123, 0, 1, 1, 0, "and_flush");

      // HLT on wrong path: flush on second drain cycle returns to RUN
      drive(1, 16'hF000, 0, 0, 1, 0, "hltw");
      drive(1, 16'h0312, 0, 0, 0, 0, "hltw_d1");
      drive(1, 16'h0312, 0, 1, 0, 0, "hltw_d2f");
      drive(1, 16'h4312, 0, 0, 1, 0, "nor_after");

      // Reset asserted during a stall with flush and valid held high
      drive(1, 16'h8415, 0, 0, 1, 0, "lw4r");
      instr_vld = 1; instr = 16'h0541; flush = 0;
      #1;
      check_eq("rst_stall_rdy", {31'b0, instr_rdy}, 32'h0);
      flush = 1; rst_n = 1'b0;
      #1;
      check_eq("rst_async_out", {2'b0, obs()}, 32'h0);
      check_eq("rst_async_rdy", {31'b0, instr_rdy}, 32'h1);
      @(posedge clk); #1;
      check_eq("rst_hold_out", {2'b0, obs()}, 32'h0);
      rst_n = 1'b1; flush = 0;
      drive(1, 16'hD123, 0, 0, 1, 0, "jal_rst");

      // Full halt: three drain cycles, halted from the fourth edge, flush ignored afterwards
      drive(1, 16'hF000, 0, 0, 1, 0, "hlt");
      drive(1, 16'h0312, 0, 0, 0, 0, "hlt_d1");
      drive(1, 16'h0312, 0, 0, 0, 0, "hlt_d2");
      drive(1, 16'h0312, 0, 0, 0, 1, "hlt_d3");
      drive(1, 16'h0312, 0, 1, 0, 1, "halt_flush");
      drive(1, 16'h0312, 0, 0, 0, 1, "halt_hold");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
